// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter.
//   uart_state_e : receiver FSM state encoding (fixed values for legacy tools)
//   calc_div     : clock cycles per bit, CLK_HZ/BAUD with integer truncation
//   even_parity  : even-parity bit for one data byte
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Parity bit that makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous input.
// Parameters:
//   RST_VAL : value both flops take during reset
// Ports:
//   clk   in  1  sampling clock
//   reset in  1  synchronous, active-high reset
//   i_d   in  1  asynchronous input
//   o_q   out 1  synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, 8 data bits LSB first, optional even parity,
// 1 stop bit. Received bytes land in a single holding register with a
// valid/ready handshake; the line is never back-pressured.
//
// Build option:
//   UART_RX_PARITY_EN  when defined, an even-parity bit follows the data bits
//                      and mismatching frames are discarded with parity_err.
//                      When undefined, frames are 10 bits and parity_err = 0.
//
// Parameters:
//   CLK_HZ  clk frequency in Hz
//   BAUD    line bit rate
// Ports:
//   clk        in  1  system clock
//   reset      in  1  synchronous, active-high reset
//   rx_in      in  1  asynchronous serial line, idle high
//   rx_data    out 8  last received byte
//   rx_valid   out 1  rx_data holds an unconsumed byte
//   rx_ready   in  1  consumer accepts rx_data this cycle
//   frame_err  out 1  one-cycle pulse: stop bit sampled low
//   overrun    out 1  one-cycle pulse: byte dropped, holding register full
//   parity_err out 1  one-cycle pulse: parity mismatch
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
    localparam int unsigned HALF  = DIV / 2;
    localparam int          CNT_W = $clog2(DIV + 1);

    localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);

    // -----------------------------------------------------------------------
    // Line synchronizer
    // -----------------------------------------------------------------------
    logic w_line;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_in),
        .o_q   (w_line)
    );

    // -----------------------------------------------------------------------
    // Bit-timing FSM
    // -----------------------------------------------------------------------
    uart_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bit;
`endif

    logic w_tick;
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Aim the first sample at the middle of the start bit.
                    if (!w_line) begin
                        r_cnt   <= HALF_LOAD;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (!w_line) begin
                            r_cnt     <= RELOAD;
                            r_bit_idx <= '0;
                            r_state   <= ST_DATA;
                        end else begin
                            // Line back high at mid-bit: treat as a glitch.
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        r_cnt <= RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= RELOAD;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (w_tick) begin
                        r_state <= w_line ? ST_IDLE : ST_BREAK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_BREAK: begin
                    // A held-low line must rise before another start bit counts.
                    if (w_line) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Data path: shift right, newest bit enters at the MSB so the first
    // (LSB) bit ends up in bit 0 after eight samples.
    always_ff @(posedge clk) begin
        if ((r_state == ST_DATA) && w_tick) begin
            r_shift <= {w_line, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if ((r_state == ST_PARITY) && w_tick) begin
            r_par_bit <= w_line;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Stop-bit decision and holding register
    // -----------------------------------------------------------------------
    logic w_stop_tick;
    logic w_stop_ok;
    logic w_stop_bad;
    logic w_par_bad;
    logic w_deliver;
    logic w_accept;

    assign w_stop_tick = (r_state == ST_STOP) && w_tick;
    assign w_stop_ok   = w_stop_tick && w_line;
    assign w_stop_bad  = w_stop_tick && !w_line;

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = w_stop_ok && (even_parity(r_shift) != r_par_bit);
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_deliver = w_stop_ok && !w_par_bad;
    // A consumer taking the old byte this cycle frees the register for the new one.
    assign w_accept  = !rx_valid || rx_ready;

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ferr;
    logic       r_ovr;
    logic       r_perr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_ferr <= w_stop_bad;
            r_perr <= w_par_bad;
            r_ovr  <= w_deliver && !w_accept;
            if (w_deliver && w_accept) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign parity_err = r_perr;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Randomized scoreboard bench for uart_rx. The stimulus side predicts each
// frame's outcome from the frame rules (stop bit, parity, holding-register
// occupancy) and queues expected bytes / error counts; an independent
// monitor pops and compares whenever a byte is handed over.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned BAUD   = 3_000_000;
    localparam int          DIV    = CLK_HZ / BAUD;   // 16 (truncated)
    localparam int          HALF   = DIV / 2;
`ifdef UART_RX_PARITY_EN
    localparam int          NPAR   = 1;
`else
    localparam int          NPAR   = 0;
`endif
    // Cycles from the start-bit edge to the edge that samples the stop bit:
    // 2 synchronizer flops + 1 idle detect, half a bit, then 8 data bits,
    // the optional parity bit and the stop bit at full spacing.
    localparam int          DELIV  = 3 + HALF + DIV * (9 + NPAR);

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    int got_ferr = 0, got_ovr = 0, got_perr = 0;
    bit model_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_ferr = 1'b0, prev_ovr = 1'b0, prev_perr = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_byte: got unexpected byte %0h, expected none", rx_data);
                end else begin
                    chk("rx_byte", rx_data, exp_q.pop_front());
                end
            end
            if (frame_err) begin
                got_ferr++;
                chk("ferr_width", prev_ferr, 0);
            end
            if (overrun) begin
                got_ovr++;
                chk("ovr_width", prev_ovr, 0);
            end
            if (parity_err) begin
                got_perr++;
                chk("perr_width", prev_perr, 0);
            end
        end
        prev_ferr = frame_err;
        prev_ovr  = overrun;
        prev_perr = parity_err;
    end

    // ---------------- reference model ----------------
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok,
                                input bit par_ok, input bit rdy_at_deliv);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (!par_ok) begin
            exp_perr++;
        end else if (model_full && !rdy_at_deliv) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(b);
            model_full = !rdy_at_deliv;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit par_ok, input int hold_low);
        logic p;
        p = ^b;
        if (!par_ok) p = ~p;
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (NPAR != 0) drive_bit(p);
        drive_bit(stop_ok);
        if (!stop_ok && hold_low > 0) begin
            repeat (hold_low) @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        expect_frame(b, stop_ok, par_ok, rx_ready);
        send_frame(b, stop_ok, par_ok, 0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        rx_ready = v;
        if (v) model_full = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_ferr"}, got_ferr, exp_ferr);
        chk({tag, "_ovr"},  got_ovr,  exp_ovr);
        chk({tag, "_perr"}, got_perr, exp_perr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a_byte;
        logic [7:0] b_byte;

        reset    = 1'b1;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_data",  rx_data,    8'h00);
        chk("rst_valid", rx_valid,   1'b0);
        chk("rst_ferr",  frame_err,  1'b0);
        chk("rst_ovr",   overrun,    1'b0);
        chk("rst_perr",  parity_err, 1'b0);
        idle(5);

        // Two back-to-back bytes with an always-ready consumer.
        xfer(8'h55, 1'b1, 1'b1);
        xfer(8'hA3, 1'b1, 1'b1);
        idle(4);
        chk_counts("basic");

        // Short low glitch (well under half a bit) must be ignored.
        @(posedge clk);
        #1;
        rx_in = 1'b0;
        idle(5);
        rx_in = 1'b1;
        idle(3 * DIV);
        xfer(8'h3C, 1'b1, 1'b1);
        idle(4);
        chk_counts("glitch");

        // Stop bit low followed by a long break.
        expect_frame(8'h81, 1'b0, 1'b1, rx_ready);
        send_frame(8'h81, 1'b0, 1'b1, 2000);
        idle(10);
        xfer(8'h7E, 1'b1, 1'b1);
        idle(4);
        chk_counts("break");

        // Consumer stalled: second byte dropped, first one kept.
        set_ready(1'b0);
        xfer(8'h11, 1'b1, 1'b1);
        xfer(8'h22, 1'b1, 1'b1);
        idle(4);
        chk("ovr_valid", rx_valid, 1'b1);
        chk("ovr_data",  rx_data,  8'h11);
        chk_counts("overrun");
        set_ready(1'b1);
        idle(4);

        // Consumer takes the held byte in the very cycle the next one lands.
        set_ready(1'b0);
        a_byte = 8'($urandom_range(1, 255));
        b_byte = 8'hC6;
        xfer(a_byte, 1'b1, 1'b1);
        idle(4);
        expect_frame(b_byte, 1'b1, 1'b1, 1'b1);
        fork
            send_frame(b_byte, 1'b1, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (DELIV - 1) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                chk("same_cycle_valid", rx_valid, 1'b1);
                chk("same_cycle_data",  rx_data,  b_byte);
                rx_ready = 1'b0;
            end
        join
        idle(4);
        chk_counts("same_cycle");
        set_ready(1'b1);
        idle(4);

        // Reset in the middle of data bit 4; that frame must vanish.
        fork
            send_frame(8'hF0, 1'b1, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (5 * DIV + 5) @(posedge clk);
                #1;
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
                chk("midrst_data",  rx_data,    8'h00);
                chk("midrst_valid", rx_valid,   1'b0);
                chk("midrst_ferr",  frame_err,  1'b0);
                chk("midrst_ovr",   overrun,    1'b0);
                chk("midrst_perr",  parity_err, 1'b0);
            end
        join
        idle(10);
        xfer(8'h0F, 1'b1, 1'b1);
        idle(4);
        chk_counts("midrst");

`ifdef UART_RX_PARITY_EN
        xfer(8'hA5, 1'b1, 1'b0);
        idle(4);
        chk("par_valid", rx_valid, 1'b0);
        chk_counts("parity");
`endif

        // Randomized frames, random gaps, occasional bad stop / parity bits.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] rb;
            bit         sok;
            bit         pok;
            rb  = 8'($urandom);
            sok = ($urandom_range(0, 4) != 0);
            pok = (NPAR == 0) || ($urandom_range(0, 5) != 0);
            xfer(rb, sok, pok);
            idle($urandom_range(2, 12));
        end
        idle(10);
        chk_counts("random");
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, the clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, the line bit rate.
REQ-003 The block SHALL have exactly one clock, clk; reset is synchronous and active-high.
- clk  input  1  system clock (CLOCK_50 at top level)
- reset  input  1  synchronous, active-high reset
- rx_in  input  1  asynchronous serial line, idle high (UART_RX pad)
- rx_data  output  8  last received byte
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts rx_data this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte dropped, holding register full
- parity_err  output  1  one-cycle pulse: parity mismatch (0 when macro absent)

Function
REQ-004 Frame SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-020), and 1 stop bit (1).
REQ-005 DIV SHALL be CLK_HZ/BAUD with integer truncation (434 at the defaults), and HALF SHALL be DIV/2 (217).
REQ-006 rx_in SHALL pass through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-007 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-008 IDLE: when the synchronized line is 0, load the bit counter with HALF-1 and go to START.
REQ-009 START: when the counter reaches 0, a line value of 0 SHALL go to DATA with counter DIV-1 and bit index 0; a line value of 1 is a glitch and SHALL return to IDLE with no output.
REQ-010 DATA: each time the counter reaches 0, sample the line into the shift register (shift right, insert at bit 7) and reload DIV-1.
REQ-011 After the 8th sample, DATA SHALL go to PARITY if the macro is defined, otherwise to STOP.
REQ-012 STOP: when the counter reaches 0, a line value of 1 SHALL deliver the byte and go to IDLE.
REQ-013 STOP: when the counter reaches 0, a line value of 0 SHALL pulse frame_err, discard the byte and go to BREAK.
REQ-014 BREAK SHALL wait until the synchronized line is 1, then go to IDLE, so a held-low line never produces bytes.
REQ-015 Delivery SHALL load rx_data and set rx_valid on the clock edge that samples the stop bit.
REQ-016 rx_valid SHALL clear on a cycle where rx_valid && rx_ready, unless a new byte is delivered in that same cycle; in that case rx_data is replaced and rx_valid stays 1.
REQ-017 If a byte is delivered while rx_valid=1 and rx_ready=0, the new byte SHALL be dropped, rx_data SHALL be unchanged, and overrun SHALL pulse for one cycle.
REQ-018 rx_data SHALL stay stable while rx_valid=1 until handshake.
REQ-019 Receiver SHALL continue to the next frame regardless of consumer state; no back-pressure reaches the line.

Configuration
REQ-020 With UART_RX_PARITY_EN defined, the PARITY state SHALL sample one even-parity bit after the data bits at the DIV spacing, then go to STOP.
REQ-021 With UART_RX_PARITY_EN defined, a parity mismatch found at STOP acceptance SHALL pulse parity_err and discard the byte; rx_valid is not set and overrun does not pulse.
REQ-022 Without UART_RX_PARITY_EN, the PARITY state SHALL be unreachable, frames SHALL be 10 bits, and parity_err SHALL be tied to 0.

Reset
REQ-023 On reset=1 at a clk edge, the FSM SHALL go to IDLE and the counter and bit index SHALL clear.
REQ-024 On reset, rx_data SHALL be 8'h00; rx_valid, frame_err, overrun and parity_err SHALL be 0; the synchronizer SHALL be 1.
REQ-025 Reset mid-frame SHALL abandon the frame without any output pulse; reception resumes at the next falling edge after reset deasserts.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state enum and a DIV computation function, reused by the existing transmitter.
REQ-027 One sub-module, uart_sync2, SHALL implement the 2-flop synchronizer with reset value parameter.

Verification
REQ-028 Defaults, send 0x55 then 0xA3 with rx_ready=1 -> rx_valid pulses twice; rx_data 0x55 then 0xA3; no error pulses.
REQ-029 Drive rx_in low for 100 cycles then high -> no rx_valid and no error pulses; a following 0x3C is received correctly.
REQ-030 Send 0x81 with stop bit 0, hold low 2000 cycles, then release -> one frame_err pulse, no rx_valid, no bytes during low; next 0x7E is received.
REQ-031 rx_ready=0, send 0x11 then 0x22 -> rx_valid=1, rx_data=0x11, one overrun pulse.
REQ-032 With rx_ready=1 asserted in the exact delivery cycle of a second byte -> rx_valid stays 1 and rx_data is the second byte.
REQ-033 Assert reset during data bit 4 of 0xF0 -> all outputs return to reset values; the next frame 0x0F is received; with UART_RX_PARITY_EN, 0xA5 with odd parity -> parity_err pulse and no rx_valid.
